vga_timing_gen: RTL

//  Free-running 640x480@60Hz VGA timing generator on the pixel clock (25 MHz nominal).

---
 rtl/vga_timing_pkg.sv | 34 +++
 rtl/sync_delay_line.sv | 33 +++
 rtl/vga_timing_gen.sv | 106 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60Hz timing constants and the idle levels of the sync/blank outputs.
// The pixel stage imports the same constants so everyone agrees on the geometry.
package vga_timing_pkg;

  localparam int CNT_W = 10;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int BLANK_DELAY_DEF = 1;
  localparam int SYNC_DELAY_DEF  = 2;

  // Both syncs are active-low, so idle is high; blank idles at "not visible".
  localparam logic HS_INACTIVE    = 1'b1;
  localparam logic VS_INACTIVE    = 1'b1;
  localparam logic BLANK_INACTIVE = 1'b0;

  // True while cnt lies in [start, start+width).
  function automatic logic in_window(input logic [CNT_W-1:0] cnt, input int start,
                                     input int width);
    return (cnt >= CNT_W'(start)) && (cnt < CNT_W'(start + width));
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Synchronous-reset shift register used to align sync/blank with the pixel pipeline.
// DEPTH of zero degenerates to a plain wire.
module sync_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster counters with sync/blank decode, pipeline-matched output delays,
// and a frame strobe/counter for game-logic pacing.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE   = H_VISIBLE_DEF,
  parameter int H_FRONT     = H_FRONT_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BACK      = H_BACK_DEF,
  parameter int V_VISIBLE   = V_VISIBLE_DEF,
  parameter int V_FRONT     = V_FRONT_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BACK      = V_BACK_DEF,
  parameter int BLANK_DELAY = BLANK_DELAY_DEF,
  parameter int SYNC_DELAY  = SYNC_DELAY_DEF
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  output logic [CNT_W-1:0] DrawX,
  output logic [CNT_W-1:0] DrawY,
  output logic             blank,
  output logic             hs,
  output logic             vs,
  output logic             frame_start,
  output logic [7:0]       frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_geometry
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed %0d", CNT_MAX);
    end
    if (BLANK_DELAY < 0 || BLANK_DELAY > 4 || SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_delay
      $error("vga_timing_gen: BLANK_DELAY/SYNC_DELAY must be within 0..4");
    end
  endgenerate

  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;
  logic [7:0]       fc;
  logic             h_end;
  logic             v_end;

  assign h_end = (hc == CNT_W'(H_TOTAL - 1));
  assign v_end = (vc == CNT_W'(V_TOTAL - 1));

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
      fc <= '0;
    end else if (h_end) begin
      hc <= '0;
      if (v_end) begin
        vc <= '0;
        fc <= fc + 8'd1;
      end else begin
        vc <= vc + CNT_W'(1);
      end
    end else begin
      hc <= hc + CNT_W'(1);
    end
  end

  // Raw decode straight off the counters; the delay lines below align it with the pixels.
  logic vis_r;
  logic hs_r;
  logic vs_r;

  always_comb begin
    vis_r = (hc < CNT_W'(H_VISIBLE)) && (vc < CNT_W'(V_VISIBLE));
    hs_r  = !in_window(hc, H_VISIBLE + H_FRONT, H_SYNC);
    vs_r  = !in_window(vc, V_VISIBLE + V_FRONT, V_SYNC);
  end

  sync_delay_line #(
    .WIDTH    (2),
    .DEPTH    (SYNC_DELAY),
    .RESET_VAL({HS_INACTIVE, VS_INACTIVE})
  ) u_sync_dly (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .d      ({hs_r, vs_r}),
    .q      ({hs, vs})
  );

  sync_delay_line #(
    .WIDTH    (1),
    .DEPTH    (BLANK_DELAY),
    .RESET_VAL(BLANK_INACTIVE)
  ) u_blank_dly (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .d      (vis_r),
    .q      (blank)
  );

  assign DrawX       = hc;
  assign DrawY       = vc;
  assign frame_count = fc;
  // Gated by reset so the strobe never fires while the counters are being held at 0,0.
  assign frame_start = reset_n && (hc == '0) && (vc == '0);

endmodule
